// File: rtl/seq_div_pkg.sv
// Shared widths and state encoding for the sequential restoring divider.
// Imported by the interface, the step datapath and the top level.
package seq_div_pkg;

  localparam int DIVIDEND_W = 17;
  localparam int DIVISOR_W  = 16;
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for seq_divider.
// master drives the request, slave is the divider.
interface seq_divider_if;
  import seq_div_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift in a dividend bit, subtract if it fits.
// Purely combinational; the top level registers the results.
module div_step
  import seq_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   r,
  input  logic                 q_msb,
  input  logic [DIVISOR_W-1:0] d,
  output logic [DIVISOR_W:0]   r_next,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] t;
  logic [DIVISOR_W+1:0] diff;

  // r always stays below d, so its top bit is zero and t fits easily
  always_comb begin
    t      = {r, q_msb};
    diff   = t - {2'b00, d};
    q_bit  = (t >= {2'b00, d});
    r_next = q_bit ? diff[DIVISOR_W:0] : t[DIVISOR_W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Holds the FSM, iteration counter and operand/result registers.
module seq_divider
  import seq_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W:0]    r;
  logic [DIVISOR_W-1:0]  d;
  logic                  busy;
  logic                  done;
  logic                  dbz;
  logic [DIVIDEND_W-1:0] quot;
  logic [DIVISOR_W-1:0]  rem;

  logic [DIVISOR_W:0]    r_next;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] q_next;

  div_step u_step (
    .r      (r),
    .q_msb  (q[DIVIDEND_W-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q[DIVIDEND_W-2:0], q_bit};

  // FSM, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.start) begin
            q   <= bus.dividend;
            d   <= bus.divisor;
            r   <= '0;
            cnt <= CNT_W'(DIVIDEND_W);
            if (bus.divisor == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              dbz   <= 1'b1;
              quot  <= '1;
              rem   <= '0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              dbz   <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          q   <= q_next;
          r   <= r_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            quot  <= q_next;
            rem   <= r_next[DIVISOR_W-1:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quot;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;

endmodule
